// File: rtl/johnson_phase_checker.sv
// rtl/johnson_phase_checker.sv - decodes a Johnson count into phase, checks the step sequence and locks onto it
// Build option JPC_HOLD_ALLOW_EN: a repeated legal code is accepted as a hold instead of a sequence break.
module johnson_phase_checker #(
  parameter int N        = 4,
  parameter int PW       = 3,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8,
  parameter int CYC_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     jc_in,
  output logic [PW-1:0]    phase,
  output logic [2*N-1:0]   phase_oh,
  output logic             valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CYC_W-1:0] cyc_cnt
);

  localparam int              P2         = 2 * N;
  localparam int              SW         = $clog2(LOCK_CNT + 1);
  localparam logic [0:0]      ST_SEARCH  = 1'b0;
  localparam logic [0:0]      ST_LOCKED  = 1'b1;
  localparam logic [PW-1:0]   LAST_PHASE = PW'(P2 - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [P2-1:0]   OH_LSB     = P2'(1);
  localparam logic [SW-1:0]   STEP_LAST  = SW'(LOCK_CNT - 1);

  // Johnson code for phase k: k ones filling from the LSB, then zeros filling from the LSB.
  function automatic logic [N-1:0] johnson_code(input int k);
    logic [N-1:0] c;
    for (int i = 0; i < N; i++) begin
      c[i] = (k <= N) ? (i < k) : (i >= k - N);
    end
    return c;
  endfunction

  logic [0:0]       state_q,      state_d;
  logic             prev_valid_q, prev_valid_d;
  logic [PW-1:0]    prev_phase_q, prev_phase_d;
  logic [SW-1:0]    step_q,       step_d;
  logic [PW-1:0]    phase_q,      phase_d;
  logic [P2-1:0]    phase_oh_q,   phase_oh_d;
  logic             valid_q,      valid_d;
  logic             illegal_q,    illegal_d;
  logic             seq_err_q,    seq_err_d;
  logic [ERR_W-1:0] err_cnt_q,    err_cnt_d;
  logic [CYC_W-1:0] cyc_cnt_q,    cyc_cnt_d;

  logic             dec_legal;
  logic [PW-1:0]    dec_phase;
  logic [PW-1:0]    succ_phase;
  logic             is_step;
  logic             is_hold;

  always_comb begin
    dec_legal = 1'b0;
    dec_phase = '0;
    for (int k = 0; k < P2; k++) begin
      if (jc_in == johnson_code(k)) begin
        dec_legal = 1'b1;
        dec_phase = PW'(k);
      end
    end
  end

  assign succ_phase = (prev_phase_q == LAST_PHASE) ? '0 : prev_phase_q + PW'(1);
  assign is_step    = prev_valid_q && dec_legal && (dec_phase == succ_phase);
`ifdef JPC_HOLD_ALLOW_EN
  assign is_hold    = prev_valid_q && dec_legal && (dec_phase == prev_phase_q);
`else
  assign is_hold    = 1'b0;
`endif

  always_comb begin
    logic err_inc;
    err_inc      = 1'b0;
    state_d      = state_q;
    prev_valid_d = prev_valid_q;
    prev_phase_d = prev_phase_q;
    step_d       = step_q;
    phase_d      = phase_q;
    phase_oh_d   = phase_oh_q;
    illegal_d    = illegal_q;
    err_cnt_d    = err_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    valid_d      = 1'b0;
    seq_err_d    = 1'b0;

    if (en) begin
      valid_d    = 1'b1;
      phase_d    = dec_phase;
      phase_oh_d = dec_legal ? (OH_LSB << dec_phase) : '0;
      illegal_d  = !dec_legal;

      if (!dec_legal) begin
        // Illegal codes always drop lock and forget the predecessor.
        err_inc      = 1'b1;
        state_d      = ST_SEARCH;
        step_d       = '0;
        prev_valid_d = 1'b0;
      end else begin
        prev_valid_d = 1'b1;
        prev_phase_d = dec_phase;
        if (!is_hold) begin
          if (state_q == ST_LOCKED) begin
            if (is_step) begin
              if (prev_phase_q == LAST_PHASE) begin
                cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
              end
            end else begin
              seq_err_d = 1'b1;
              err_inc   = 1'b1;
              state_d   = ST_SEARCH;
              step_d    = '0;
            end
          end else if (is_step) begin
            if (step_q == STEP_LAST) begin
              state_d = ST_LOCKED;
              step_d  = '0;
            end else begin
              step_d = step_q + SW'(1);
            end
          end else begin
            step_d = '0;
          end
        end
      end

      if (err_inc && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SEARCH;
      prev_valid_q <= 1'b0;
      prev_phase_q <= '0;
      step_q       <= '0;
      phase_q      <= '0;
      phase_oh_q   <= '0;
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= prev_valid_d;
      prev_phase_q <= prev_phase_d;
      step_q       <= step_d;
      phase_q      <= phase_d;
      phase_oh_q   <= phase_oh_d;
      valid_q      <= valid_d;
      illegal_q    <= illegal_d;
      seq_err_q    <= seq_err_d;
      err_cnt_q    <= err_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
    end
  end

  assign phase    = phase_q;
  assign phase_oh = phase_oh_q;
  assign valid    = valid_q;
  assign illegal  = illegal_q;
  assign seq_err  = seq_err_q;
  assign locked   = (state_q == ST_LOCKED);
  assign err_cnt  = err_cnt_q;
  assign cyc_cnt  = cyc_cnt_q;

endmodule

// File: tb/tb_johnson_phase_checker.sv
// tb/tb_johnson_phase_checker.sv - randomized bench for johnson_phase_checker against a behavioural model
// Build option JPC_HOLD_ALLOW_EN switches the model to hold-tolerant repeats.
module tb_johnson_phase_checker;

  localparam int N        = 4;
  localparam int PW       = 3;
  localparam int LOCK_CNT = 2;
  localparam int ERR_W    = 8;
  localparam int CYC_W    = 16;
  localparam int ERR_SAT  = (1 << ERR_W) - 1;
`ifdef JPC_HOLD_ALLOW_EN
  localparam bit HOLD_OK = 1'b1;
`else
  localparam bit HOLD_OK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic [N-1:0]     jc_in = '0;
  logic [PW-1:0]    phase;
  logic [2*N-1:0]   phase_oh;
  logic             valid;
  logic             illegal;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;
  logic [CYC_W-1:0] cyc_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int m_phase, m_oh, m_valid, m_illegal, m_seq, m_locked, m_err, m_cyc;
  int m_prev;   // -1 means no predecessor
  int m_steps;

  johnson_phase_checker #(
    .N(N), .PW(PW), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .jc_in(jc_in),
    .phase(phase), .phase_oh(phase_oh), .valid(valid), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int code_of(input int k);
    if (k <= N) return (1 << k) - 1;
    return ((1 << N) - 1) ^ ((1 << (k - N)) - 1);
  endfunction

  function automatic int ref_decode(input int code);
    int p;
    p = $countones(code & ((1 << N) - 1));
    if (code == (1 << p) - 1) return p;
    if (p > 0 && p < N && code == (((1 << N) - 1) ^ ((1 << (N - p)) - 1))) return 2 * N - p;
    return -1;
  endfunction

  task automatic model_update(input bit r, input bit e, input int code);
    int  ph;
    bit  succ, hold;
    if (r) begin
      m_phase = 0; m_oh = 0; m_valid = 0; m_illegal = 0; m_seq = 0;
      m_locked = 0; m_err = 0; m_cyc = 0; m_prev = -1; m_steps = 0;
      return;
    end
    m_seq   = 0;
    m_valid = e;
    if (!e) return;
    ph = ref_decode(code);
    if (ph < 0) begin
      m_illegal = 1; m_oh = 0; m_locked = 0; m_prev = -1; m_steps = 0;
      if (m_err < ERR_SAT) m_err++;
      return;
    end
    m_illegal = 0;
    m_phase   = ph;
    m_oh      = 1 << ph;
    succ = (m_prev >= 0) && (ph == (m_prev + 1) % (2 * N));
    hold = HOLD_OK && (m_prev >= 0) && (ph == m_prev);
    if (!hold) begin
      if (m_locked != 0) begin
        if (succ) begin
          if (m_prev == 2 * N - 1) m_cyc = (m_cyc + 1) % (1 << CYC_W);
        end else begin
          m_seq = 1; m_locked = 0; m_steps = 0;
          if (m_err < ERR_SAT) m_err++;
        end
      end else if (succ) begin
        m_steps++;
        if (m_steps >= LOCK_CNT) begin
          m_locked = 1; m_steps = 0;
        end
      end else begin
        m_steps = 0;
      end
    end
    m_prev = ph;
  endtask

  task automatic step_cycle(input bit r, input bit e, input int code);
    @(negedge clk);
    reset = r; en = e; jc_in = N'(code);
    @(posedge clk);
    #1;
    model_update(r, e, code);
    check_val("valid",   int'(valid),    m_valid);
    check_val("illegal", int'(illegal),  m_illegal);
    check_val("seq_err", int'(seq_err),  m_seq);
    check_val("locked",  int'(locked),   m_locked);
    check_val("err_cnt", int'(err_cnt),  m_err);
    check_val("cyc_cnt", int'(cyc_cnt),  m_cyc);
    check_val("phase_oh", int'(phase_oh), m_oh);
    if (m_illegal == 0) check_val("phase", int'(phase), m_phase);
  endtask

  initial begin
    int cur, pick, code;
    bit r, e;

    step_cycle(1, 0, 0);
    step_cycle(0, 0, 0);

    // Lock-in from reset
    step_cycle(0, 1, 'b0000);
    step_cycle(0, 1, 'b0001);
    check_val("plan_unlocked", int'(locked), 0);
    step_cycle(0, 1, 'b0011);
    check_val("plan_phase2_oh", int'(phase_oh), 'h04);
    check_val("plan_locked", int'(locked), 1);

    // Walk to a full cycle wrap
    for (int k = 3; k <= 8; k++) step_cycle(0, 1, code_of(k % 8));
    check_val("plan_cyc1", int'(cyc_cnt), 1);
    for (int k = 1; k <= 3; k++) step_cycle(0, 1, code_of(k));

    // Non-successor while locked, then relock
    step_cycle(0, 1, 'b1100);
    check_val("plan_seq_err", int'(seq_err), 1);
    check_val("plan_seq_phase", int'(phase), 6);
    check_val("plan_seq_err_cnt", int'(err_cnt), 1);
    step_cycle(0, 1, 'b1000);
    step_cycle(0, 1, 'b0000);
    check_val("plan_relock", int'(locked), 1);

    // Illegal code, then relock needs a fresh run
    step_cycle(0, 1, 'b0101);
    check_val("plan_illegal_oh", int'(phase_oh), 0);
    step_cycle(0, 1, 'b0001);
    check_val("plan_no_relock", int'(locked), 0);
    step_cycle(0, 1, 'b0011);
    step_cycle(0, 1, 'b0111);

    // Repeated code while locked (behaviour depends on build option)
    step_cycle(0, 1, 'b0111);
    step_cycle(0, 0, 'b0101);

    // Saturate the error counter
    for (int i = 0; i < ERR_SAT + 5; i++) step_cycle(0, 1, (i % 2 == 0) ? 'b1010 : 'b0010);
    check_val("plan_err_sat", int'(err_cnt), ERR_SAT);

    // Reset wins over a simultaneous legal sample
    step_cycle(1, 1, 'b0001);
    check_val("plan_rst_valid", int'(valid), 0);

    // Randomized traffic
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 249) == 0);
      e    = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 99);
      if (pick < 80) begin
        cur  = (cur + 1) % (2 * N);
        code = code_of(cur);
      end else if (pick < 88) begin
        code = code_of(cur);
      end else if (pick < 94) begin
        cur  = $urandom_range(0, 2 * N - 1);
        code = code_of(cur);
      end else begin
        code = $urandom_range(0, (1 << N) - 1);
      end
      step_cycle(r, e, code);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
